// File: rtl/io_port_buffer_pkg.sv
// Shared word/FIFO sizing and register-file index constants for the I/O port buffer.
package io_port_buffer_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int FIFO_DEPTH = 4;

  localparam logic [3:0] REG_ZERO   = 4'd0;
  localparam logic [3:0] REG_ISZERO = 4'd3;
  localparam logic [3:0] REG_IN     = 4'd13;
  localparam logic [3:0] REG_OUT    = 4'd14;
  localparam logic [3:0] REG_ACC    = 4'd15;

  function automatic int fifo_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/io_port_buffer_sync_fifo.sv
// Single-clock FIFO with guarded push/pop and a zeroed head when empty.
module sync_fifo
  import io_port_buffer_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = fifo_count_width(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == {CW{1'b0}});
  // Flags are taken pre-edge: a pop never frees room for a same-cycle push when full.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/io_port_buffer.sv
// I/O port buffer: external input FIFO feeding R13 writes, and R14 captures draining to an external consumer.
module io_port_buffer
  import io_port_buffer_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ext_in_valid,
  input  logic [WIDTH-1:0] ext_in_data,
  output logic             ext_in_ready,
  input  logic             in_pop,
  output logic [WIDTH-1:0] in_data,
  output logic             in_data_write,
  output logic             in_empty,
  input  logic             out_push,
  input  logic [WIDTH-1:0] out_data,
  output logic             out_full,
  output logic             out_overflow,
  output logic             ext_out_valid,
  output logic [WIDTH-1:0] ext_out_data,
  input  logic             ext_out_ready
);

  logic             in_full;
  logic [WIDTH-1:0] in_head;
  logic             out_empty;
  logic [WIDTH-1:0] in_data_q, in_data_d;
  logic             in_write_q, in_write_d;
  logic             overflow_q, overflow_d;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
    .clock (clock),
    .reset (reset),
    .push  (ext_in_valid),
    .pop   (in_pop),
    .wdata (ext_in_data),
    .rdata (in_head),
    .full  (in_full),
    .empty (in_empty)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
    .clock (clock),
    .reset (reset),
    .push  (out_push),
    .pop   (ext_out_ready),
    .wdata (out_data),
    .rdata (ext_out_data),
    .full  (out_full),
    .empty (out_empty)
  );

  assign ext_in_ready  = !in_full;
  assign ext_out_valid = !out_empty;
  assign in_data       = in_data_q;
  assign in_data_write = in_write_q;
  assign out_overflow  = overflow_q;

  always_comb begin
    in_data_d  = in_data_q;
    in_write_d = in_pop && !in_empty;
    if (in_write_d) begin
      in_data_d = in_head;
    end else begin
      in_data_d = in_data_q;
    end
    // Sticky until reset: any push refused because the output FIFO was full.
    if (out_push && out_full) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_data_q  <= {WIDTH{1'b0}};
      in_write_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      in_data_q  <= in_data_d;
      in_write_q <= in_write_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_io_port_buffer.sv
// Randomized + directed bench: queue-based reference model and a decoupled scoreboard monitor.
module tb_io_port_buffer;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         ext_in_valid = 1'b0;
  logic [W-1:0] ext_in_data = '0;
  logic         ext_in_ready;
  logic         in_pop = 1'b0;
  logic [W-1:0] in_data;
  logic         in_data_write;
  logic         in_empty;
  logic         out_push = 1'b0;
  logic [W-1:0] out_data = '0;
  logic         out_full;
  logic         out_overflow;
  logic         ext_out_valid;
  logic [W-1:0] ext_out_data;
  logic         ext_out_ready = 1'b0;

  io_port_buffer #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .ext_in_valid(ext_in_valid), .ext_in_data(ext_in_data), .ext_in_ready(ext_in_ready),
    .in_pop(in_pop), .in_data(in_data), .in_data_write(in_data_write), .in_empty(in_empty),
    .out_push(out_push), .out_data(out_data), .out_full(out_full), .out_overflow(out_overflow),
    .ext_out_valid(ext_out_valid), .ext_out_data(ext_out_data), .ext_out_ready(ext_out_ready)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  // Reference model state: FIFO contents as queues, plus what R13 should show.
  logic [W-1:0] in_m[$];
  logic [W-1:0] out_m[$];
  logic [W-1:0] exp_in_q[$];
  logic [W-1:0] exp_out_q[$];
  logic [W-1:0] in_data_exp = '0;
  logic         strobe_exp  = 1'b0;
  logic         ovf_exp     = 1'b0;
  logic         mon_en      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard monitor: compares every delivered word against the expected queue.
  always @(negedge clock) begin
    if (mon_en) begin
      if (in_data_write) begin
        if (exp_in_q.size() == 0) chk("in_unexpected_strobe", 32'd1, 32'd0);
        else chk("in_word", {16'h0, in_data}, {16'h0, exp_in_q.pop_front()});
      end
      if (ext_out_valid && ext_out_ready) begin
        if (exp_out_q.size() == 0) chk("out_unexpected_word", 32'd1, 32'd0);
        else chk("out_word", {16'h0, ext_out_data}, {16'h0, exp_out_q.pop_front()});
      end
    end
  end

  task automatic step(input logic iv, input logic [W-1:0] id, input logic ip,
                      input logic op, input logic [W-1:0] od, input logic ordy);
    logic in_acc, in_take, out_acc, out_take;
    ext_in_valid = iv; ext_in_data = id; in_pop = ip;
    out_push = op; out_data = od; ext_out_ready = ordy;
    @(negedge clock);
    chk("ext_in_ready", ext_in_ready, in_m.size() < DEPTH);
    chk("in_empty", in_empty, in_m.size() == 0);
    chk("in_data_write", in_data_write, strobe_exp);
    chk("in_data", in_data, in_data_exp);
    chk("out_full", out_full, out_m.size() == DEPTH);
    chk("ext_out_valid", ext_out_valid, out_m.size() > 0);
    chk("ext_out_data", ext_out_data, (out_m.size() > 0) ? out_m[0] : 16'h0000);
    chk("out_overflow", out_overflow, ovf_exp);
    in_acc   = iv && (in_m.size() < DEPTH);
    in_take  = ip && (in_m.size() > 0);
    out_acc  = op && (out_m.size() < DEPTH);
    out_take = ordy && (out_m.size() > 0);
    strobe_exp = in_take;
    if (in_take) begin
      in_data_exp = in_m.pop_front();
      exp_in_q.push_back(in_data_exp);
    end
    if (in_acc) in_m.push_back(id);
    if (op && !out_acc) ovf_exp = 1'b1;
    if (out_take) void'(out_m.pop_front());
    if (out_acc) begin
      out_m.push_back(od);
      exp_out_q.push_back(od);
    end
    @(posedge clock); #1;
  endtask

  // Asserts reset away from any clock edge and checks outputs respond without a clock.
  task automatic pulse_reset();
    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_ext_in_ready", ext_in_ready, 1'b1);
    chk("rst_in_empty", in_empty, 1'b1);
    chk("rst_ext_out_valid", ext_out_valid, 1'b0);
    chk("rst_out_overflow", out_overflow, 1'b0);
    chk("rst_in_data_write", in_data_write, 1'b0);
    chk("rst_in_data", in_data, 16'h0000);
    chk("rst_out_full", out_full, 1'b0);
    chk("rst_ext_out_data", ext_out_data, 16'h0000);
    ext_in_valid = 1'b0; in_pop = 1'b0; out_push = 1'b0; ext_out_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    in_m.delete(); out_m.delete(); exp_in_q.delete(); exp_out_q.delete();
    in_data_exp = '0; strobe_exp = 1'b0; ovf_exp = 1'b0;
    @(posedge clock); #1;
    mon_en = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    mon_en = 1'b1;
    pulse_reset();

    // Fill the input FIFO, hold a fifth word while full, then drain including a pop on empty.
    step(1, 16'h0011, 0, 0, 0, 0);
    step(1, 16'h0022, 0, 0, 0, 0);
    step(1, 16'h0033, 0, 0, 0, 0);
    step(1, 16'h0044, 0, 0, 0, 0);
    step(1, 16'h0055, 0, 0, 0, 0);
    step(1, 16'h0055, 0, 0, 0, 0);
    step(1, 16'h0055, 1, 0, 0, 0);
    step(1, 16'h0055, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 16'h0000, 1, 0, 0, 0);
    step(0, 16'h0000, 1, 0, 0, 0);
    step(0, 16'h0000, 0, 0, 0, 0);
    step(1, 16'hBEEF, 1, 0, 0, 0);
    step(0, 16'h0000, 1, 0, 0, 0);
    step(0, 16'h0000, 0, 0, 0, 0);

    // Output path under backpressure.
    step(0, 0, 0, 1, 16'h1234, 0);
    step(0, 0, 0, 1, 16'hABCD, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 16'h0000, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 16'h0000, 1);

    // Overflow: five pushes into a four-deep FIFO, then a push coinciding with a pop while full.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 16'hC000 + 16'(i), 0);
    step(0, 0, 0, 1, 16'hD000, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 16'h0000, 1);

    // Reset mid-operation with a write strobe in flight.
    pulse_reset();
    step(1, 16'h0A01, 0, 1, 16'h0B01, 0);
    step(1, 16'h0A02, 0, 1, 16'h0B02, 0);
    step(0, 16'h0000, 1, 0, 16'h0000, 0);
    pulse_reset();
    for (int i = 0; i < 10; i++) step(1, 16'h0E00 + 16'(i), 1, 1, 16'h0F00 + 16'(i), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 1);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), 16'($urandom), $urandom_range(0, 1),
           $urandom_range(0, 1), 16'($urandom), ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 1);

    chk("in_scoreboard_drained", exp_in_q.size(), 32'd0);
    chk("out_scoreboard_drained", exp_out_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/io_port_buffer.md
Name: io_port_buffer

Overview:
- Buffers external I/O traffic for the register file.
- Input side: accepts words from an external producer over valid/ready into a small FIFO. On a control pop, delivers the next word as a one-cycle write into the input register (R13) through the register file's in_data/in_data_write ports.
- Output side: on a control push, captures the output register (R14) value into a FIFO, which drains to an external consumer over valid/ready.
- Sits between the chip-level I/O pins and the register file; driven by the control unit for IN/OUT instructions.

Parameters:
WIDTH, 16, data word width (matches register file word).
DEPTH, 4, entries per FIFO; power of two, >= 2.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
ext_in_valid  input  1  external producer has a word.
ext_in_data  input  WIDTH  external input word.
ext_in_ready  output  1  input FIFO can accept a word.
in_pop  input  1  control requests next input word into R13.
in_data  output  WIDTH  word to register file R13.
in_data_write  output  1  one-cycle write strobe to register file.
in_empty  output  1  input FIFO empty; control stalls IN on this.
out_push  input  1  control requests R14 be sent out.
out_data  input  WIDTH  current R14 contents from register file.
out_full  output  1  output FIFO full; control stalls OUT on this.
out_overflow  output  1  sticky: a push was dropped while full.
ext_out_valid  output  1  output FIFO has a word.
ext_out_data  output  WIDTH  head of output FIFO.
ext_out_ready  input  1  external consumer accepts the word.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high. Clock port is named clock and reset port is named reset.
- Reset, applied asynchronously:
  - Both FIFOs empty; pointers and counts set to 0.
  - in_data=0, in_data_write=0, out_overflow=0.
  - Derived outputs: ext_in_ready=1, in_empty=1, out_full=0, ext_out_valid=0, ext_out_data=0.
- Reset asserted mid-transfer discards all buffered words. No partial write strobe may be emitted.
- FIFO mechanics:
  - Count width is clog2(DEPTH)+1.
  - Read and write pointers wrap modulo DEPTH.
  - full = (count==DEPTH); empty = (count==0).
- Input side:
  - ext_in_ready = !in_full (combinational from count).
  - Push occurs when ext_in_valid && ext_in_ready.
  - Pop occurs when in_pop && !in_empty. The cycle after a pop (cycle N+1), in_data holds the popped head (registered) and in_data_write=1 for exactly one cycle. R13 updates at the end of cycle N+1, giving latency 1.
  - in_pop while empty: ignored. No strobe, no pointer change, in_data unchanged.
  - Simultaneous push and pop when empty: push occurs, pop ignored (no bypass). Count becomes 1.
  - Simultaneous push and pop when full: not possible, because ready is low while full. Only the pop occurs and count becomes DEPTH-1.
  - Simultaneous push and pop otherwise: count unchanged and both pointers advance.
  - in_data_write may be high on consecutive cycles for back-to-back pops.
- Output side:
  - Push occurs when out_push && !out_full; out_data is sampled on that rising edge.
  - out_push while full: the word is dropped and out_overflow is set. out_overflow stays set until reset.
  - ext_out_valid = !out_empty. ext_out_data = storage[rd_ptr], combinational, and is 0 when empty.
  - Pop occurs when ext_out_valid && ext_out_ready.
  - While ext_out_valid && !ext_out_ready, ext_out_data and ext_out_valid hold stable.
  - Simultaneous push and pop when full: the pop frees a slot only next cycle. out_full is evaluated pre-edge, so the push is dropped and out_overflow is set. Control must honour out_full.
- Word order is strictly FIFO on both sides. No data-dependent behaviour.

Decomposition:
- Shared package/include holds:
  - WORD_WIDTH=16 and FIFO_DEPTH=4 defaults.
  - Register index constants: REG_ZERO=0, REG_ISZERO=3, REG_IN=13, REG_OUT=14, REG_ACC=15.
- One sub-module, sync_fifo, is instantiated twice. It is parameterised by WIDTH/DEPTH, with push, pop, wdata, rdata (head), full, empty, and an async active-high reset.
- Top level adds the input output register, the write strobe and the overflow flag.

Test Plan:
- Reset state: reset pulsed mid-cycle with no clock edge -> outputs immediately at reset values (ext_in_ready=1, in_empty=1, ext_out_valid=0, out_overflow=0).
- Input path: push 0x0011, 0x0022, 0x0033, 0x0044 -> ext_in_ready=0 after the fourth. A fifth word 0x0055 held valid is not accepted. in_pop at N -> in_data=0x0011 with in_data_write=1 at N+1 only, and ext_in_ready=1 at N+1.
- Pop on empty: in_pop with in_empty=1 -> no in_data_write, in_data unchanged. Simultaneous ext push 0xBEEF and in_pop on empty -> count 1, later pop yields 0xBEEF.
- Output path with backpressure: push R14=0x1234, then 0xABCD, with ext_out_ready=0 for 3 cycles -> ext_out_data stays 0x1234 with valid=1. Raise ready -> 0x1234 then 0xABCD observed, then valid=0.
- Output overflow: 5 out_push with ext_out_ready=0 -> out_full=1 after 4 pushes, fifth word dropped, out_overflow=1 and sticky. Drain yields exactly the first four in order.
- Reset mid-operation: 2 words in each FIFO and a pop pending, assert reset -> both FIFOs empty, in_data_write=0 and no strobe after release, pointers wrap correctly over 10 subsequent push/pop pairs.
